wrr_arb_tree: RTL and testbench



---
 rtl/wrr_arb_tree.sv | 166 ++++++++++++++++
 tb/tb_wrr_arb_tree.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter: each input keeps the grant for up to weight_i[i] handshakes.
// Optional output register stage when WRR_ARB_OUT_REG_EN is defined (default: combinational path).
module wrr_arb_tree #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]             req_i,
  output logic [NumIn-1:0]             gnt_o,
  input  logic [NumIn*DataWidth-1:0]   data_i,
  output logic                         req_o,
  input  logic                         gnt_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [IdxWidth-1:0]          idx_o,
  output logic                         last_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

  logic [NumIn-1:0][WeightWidth-1:0] wgt;
  logic [NumIn-1:0][DataWidth-1:0]   din;
  logic [NumIn-1:0]                  elig;

  assign wgt = weight_i;
  assign din = data_i;

  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NumIn); i++) elig[i] = req_i[i] & (wgt[i] != '0);
  end

  logic [IdxWidth-1:0]    cur_q, cur_d;
  logic [WeightWidth-1:0] cnt_q, cnt_d;
  logic                   lock_q, lock_d;
  logic [IdxWidth-1:0]    sel_q, sel_d;
  // weight of the locked input, so a quota reload after a stall ignores weight changes
  logic [WeightWidth-1:0] wlk_q, wlk_d;

  logic                   acc;
  logic                   found;
  logic [IdxWidth-1:0]    cand, srch, s;
  logic                   req_c, cont, last_c, hs;
  logic [WeightWidth-1:0] w_s, cnt_nx;
  logic [DataWidth-1:0]   data_c;
  logic [IdxWidth-1:0]    idx_c;
  logic [NumIn-1:0]       gnt_c;

  // cyclic search starting after cur_q, cur_q itself is visited last
  always_comb begin
    found = 1'b0;
    srch  = '0;
    cand  = cur_q;
    for (int k = 0; k < int'(NumIn); k++) begin
      cand = (cand == LastIdx) ? '0 : cand + IdxWidth'(1);
      if (!found && elig[cand]) begin
        found = 1'b1;
        srch  = cand;
      end
    end
  end

  always_comb begin
    s     = srch;
    req_c = found;
    if (lock_q) begin
      s     = sel_q;
      req_c = 1'b1;
    end else if (elig[cur_q] && (cnt_q != '0)) begin
      s     = cur_q;
      req_c = 1'b1;
    end
    w_s    = lock_q ? wlk_q : wgt[s];
    cont   = (s == cur_q) && (cnt_q != '0);
    cnt_nx = cont ? cnt_q - WeightWidth'(1) : w_s - WeightWidth'(1);
    last_c = req_c & (cnt_nx == '0);
    hs     = req_c & acc;
    idx_c  = req_c ? s : '0;
    data_c = req_c ? din[s] : '0;
    gnt_c    = '0;
    gnt_c[s] = hs;
  end

  always_comb begin
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    lock_d = req_c & ~acc;
    sel_d  = s;
    wlk_d  = w_s;
    if (hs) begin
      cur_d = s;
      cnt_d = cnt_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      cur_q  <= LastIdx;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      sel_q  <= '0;
      wlk_q  <= '0;
    end else begin
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      sel_q  <= sel_d;
      wlk_q  <= wlk_d;
    end
  end

  assign gnt_o = gnt_c;

`ifdef WRR_ARB_OUT_REG_EN
  logic                 req_o_q, req_o_d;
  logic                 last_o_q, last_o_d;
  logic [DataWidth-1:0] data_o_q, data_o_d;
  logic [IdxWidth-1:0]  idx_o_q, idx_o_d;

  // register accepts whenever it is empty or being drained
  assign acc = ~req_o_q | gnt_i;

  always_comb begin
    req_o_d  = req_o_q;
    last_o_d = last_o_q;
    data_o_d = data_o_q;
    idx_o_d  = idx_o_q;
    if (acc) begin
      req_o_d  = req_c;
      last_o_d = last_c;
      data_o_d = data_c;
      idx_o_d  = idx_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      req_o_q  <= 1'b0;
      last_o_q <= 1'b0;
      data_o_q <= '0;
      idx_o_q  <= '0;
    end else begin
      req_o_q  <= req_o_d;
      last_o_q <= last_o_d;
      data_o_q <= data_o_d;
      idx_o_q  <= idx_o_d;
    end
  end

  assign req_o  = req_o_q;
  assign last_o = last_o_q;
  assign data_o = data_o_q;
  assign idx_o  = idx_o_q;
`else
  assign acc    = gnt_i;
  assign req_o  = req_c;
  assign last_o = last_c;
  assign data_o = data_c;
  assign idx_o  = idx_c;
`endif

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Randomised bench for wrr_arb_tree with a burst/quota reference model and directed literal checks.
module tb_wrr_arb_tree;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, flush, gnt;
  logic [N-1:0]          req;
  logic [N-1:0][WW-1:0]  wgt;
  logic [N-1:0][DW-1:0]  data;
  logic [N-1:0]          gnt_o;
  logic                  req_o, last_o;
  logic [DW-1:0]         data_o;
  logic [IW-1:0]         idx_o;

  wrr_arb_tree #(.NumIn(N), .DataWidth(DW), .WeightWidth(WW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .weight_i(wgt), .req_i(req),
    .gnt_o(gnt_o), .data_i(data), .req_o(req_o), .gnt_i(gnt), .data_o(data_o),
    .idx_o(idx_o), .last_o(last_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: burst owner, handshakes left in its burst, and the offered-but-stalled input.
  int m_own, m_left, m_pend, m_pw;
  bit m_init = 1'b0;

  function automatic void model_eval(output bit v, output int pick, output int wt, output int nl);
    bit e[N];
    int c;
    v = 1'b0; pick = 0; wt = 0;
    for (int i = 0; i < N; i++) e[i] = req[i] && (wgt[i] != 0);
    if (m_pend >= 0) begin
      v = 1'b1; pick = m_pend; wt = m_pw;
    end else if (e[m_own] && m_left > 0) begin
      v = 1'b1; pick = m_own; wt = int'(wgt[m_own]);
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_own + k) % N;
        if (!v && e[c]) begin
          v = 1'b1; pick = c; wt = int'(wgt[c]);
        end
      end
    end
    nl = (pick == m_own && m_left > 0) ? m_left - 1 : wt - 1;
  endfunction

  always @(posedge clk) begin
    bit v; int pick, wt, nl;
    if (!rst_n || flush) begin
      m_own = N - 1; m_left = 0; m_pend = -1; m_pw = 0; m_init = 1'b1;
    end else if (m_init) begin
      model_eval(v, pick, wt, nl);
      if (v && gnt) begin
        m_own = pick; m_left = nl;
      end
      m_pend = (v && !gnt) ? pick : -1;
      m_pw   = wt;
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    bit v; int pick, wt, nl;
    if (m_init) begin
      if (m_pend >= 0) assert (req[m_pend]) else $error("locked requester dropped req_i");
      model_eval(v, pick, wt, nl);
      chk("req_o",  longint'(req_o),  longint'(v));
      chk("idx_o",  longint'(idx_o),  v ? longint'(pick) : 0);
      chk("data_o", longint'(data_o), v ? longint'(data[pick]) : 0);
      chk("gnt_o",  longint'(gnt_o),  (v && gnt) ? (longint'(1) << pick) : 0);
      chk("last_o", longint'(last_o), longint'(v && nl == 0));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    wgt[0] = WW'(w0); wgt[1] = WW'(w1); wgt[2] = WW'(w2); wgt[3] = WW'(w3);
  endtask

  int e1_idx[14]  = '{0,1,1,2,2,2,3,0,1,1,2,2,2,3};
  bit e1_last[14] = '{1,0,1,0,0,1,1,1,0,1,0,0,1,1};
  int e2_gnt[6]   = '{1,1,4,4,1,1};
  int e3_idx[4]   = '{1,1,1,2};
  int e5_idx[4]   = '{0,0,0,1};
  bit e5_last[4]  = '{0,0,1,1};
  int e6_idx[4]   = '{0,1,2,2};

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b0; flush = 1'b0; gnt = 1'b0; req = '0;
    set_w(1, 1, 1, 1);
    for (int i = 0; i < N; i++) data[i] = $urandom;
    step(); step();
    rst_n = 1'b1;

    // weights {1,2,3,1}, everyone requesting
    set_w(1, 2, 3, 1); req = 4'b1111; gnt = 1'b1;
    settle();
    chk("after_reset_req_o", longint'(req_o), 1);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) settle();
      chk($sformatf("t1_idx[%0d]", c), longint'(idx_o), longint'(e1_idx[c]));
      chk($sformatf("t1_last[%0d]", c), longint'(last_o), longint'(e1_last[c]));
      step();
    end

    do_reset();
    set_w(2, 2, 2, 2); req = 4'b0101; gnt = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk($sformatf("t2_gnt[%0d]", c), longint'(gnt_o), longint'(e2_gnt[c]));
      step();
    end

    do_reset();
    set_w(1, 3, 1, 1); req = 4'b0110; gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t3_stall_idx", longint'(idx_o), 1);
      chk("t3_stall_req", longint'(req_o), 1);
      step();
    end
    gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t3_idx[%0d]", c), longint'(idx_o), longint'(e3_idx[c]));
      step();
    end

    do_reset();
    set_w(1, 1, 0, 1); req = 4'b0100; gnt = 1'b1;
    settle();
    chk("t4_masked_req", longint'(req_o), 0);
    chk("t4_masked_gnt", longint'(gnt_o), 0);
    step();
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t4_only0_gnt", longint'(gnt_o), 1);
      step();
    end

    do_reset();
    set_w(3, 1, 1, 1); req = 4'b0011; gnt = 1'b1;
    settle();
    chk("t5_first", longint'(idx_o), 0);
    step();
    req = 4'b0010;
    settle();
    chk("t5_drop", longint'(idx_o), 1);
    step();
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t5_idx[%0d]", c), longint'(idx_o), longint'(e5_idx[c]));
      chk($sformatf("t5_last[%0d]", c), longint'(last_o), longint'(e5_last[c]));
      step();
    end

    do_reset();
    set_w(1, 1, 4, 1); req = 4'b1111; gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t6_idx[%0d]", c), longint'(idx_o), longint'(e6_idx[c]));
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    chk("t6_after_flush", longint'(idx_o), 0);
    step();

    // random phase
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 79) == 0);
      r = N'($urandom);
      if (m_pend >= 0) r[m_pend] = 1'b1;
      req = r;
      gnt = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0) wgt[$urandom_range(0, N-1)] = WW'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) data[i] = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
